uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_if.sv | 48 ++++
 rtl/baud_tick_gen.sv | 33 +++
 rtl/uart_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Purpose: shared types and constants for the UART receiver and the debug unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: receiver FSM state encoding and the ASCII command bytes that the
// debug unit decodes from received characters. The PARITY state exists only
// when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } rx_state_t;

    // Debug-unit command characters.
    localparam logic [7:0] CMD_STEP = 8'h73;   // 's'
    localparam logic [7:0] CMD_INFO = 8'h69;   // 'i'

endpackage

// File: rtl/uart_rx_if.sv
// Purpose: bundles the UART receiver's line input, flush strobe and result outputs.
// Latency: n/a (wiring only).
// Backpressure: none; results are single-cycle pulses with no ready return.
//
// Signals: i_rx serial line (idle high), i_clear flush strobe, o_data last good
// byte, o_rx_ready / o_frame_err result pulses, o_busy frame in progress,
// o_parity_err only when UART_RX_PARITY_EN is defined.
// slave = the receiver, master = the side driving the line and consuming results.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_rx;
    logic                 i_clear;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_rx_ready;
    logic                 o_frame_err;
    logic                 o_busy;
`ifdef UART_RX_PARITY_EN
    logic                 o_parity_err;
`endif

    modport slave (
        input  i_rx,
        input  i_clear,
        output o_data,
        output o_rx_ready,
        output o_frame_err,
        output o_busy
`ifdef UART_RX_PARITY_EN
        ,
        output o_parity_err
`endif
    );

    modport master (
        output i_rx,
        output i_clear,
        input  o_data,
        input  o_rx_ready,
        input  o_frame_err,
        input  o_busy
`ifdef UART_RX_PARITY_EN
        ,
        input  o_parity_err
`endif
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Purpose: divides i_clk down to the oversampling tick.
// Latency: tick is high for one cycle when the counter sits at DIVISOR-1.
// Backpressure: none; free-running apart from the synchronous clear.
//
// Ports: i_clk, i_reset (async, active-high), clear (restart count at 0 on
// the next edge), tick (one-cycle strobe every DIVISOR cycles).
module baud_tick_gen #(
    parameter int DIVISOR = 326
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// Purpose: oversampling UART receiver, LSB-first, one stop bit.
// Latency: o_rx_ready one i_clk after the mid-stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: none; o_data is held until the next good byte, pulses are not retried.
//
// Ports: i_clk, i_reset (async, active-high), bus (uart_rx_if.slave):
//   i_rx, i_clear in; o_data, o_rx_ready, o_frame_err, o_busy out.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the
// data bits and the o_parity_err output; a parity mismatch suppresses o_rx_ready.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16,
    parameter int DIVISOR   = 326
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_rx_if.slave bus
);

    localparam int SW = (SB_TICKS  > 1) ? $clog2(SB_TICKS)  : 1;
    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif
    localparam int FLUSH_TICKS = FRAME_BITS * SB_TICKS;
    localparam int FW          = $clog2(FLUSH_TICKS);

    localparam logic [SW-1:0] S_MID  = SW'(SB_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FLUSH_TICKS - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick;
    logic                 start_ok;

    rx_state_t            state;
    logic [SW-1:0]        s;
    logic [NW-1:0]        n;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_q;
    logic                 rx_ready_q;
    logic                 frame_err_q;
    logic                 busy_q;
    logic                 wait_high;
    logic                 flushing;
    logic [FW-1:0]        flush_cnt;
    logic                 parity_ok;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
    logic                 parity_err_q;
`endif

    // Two-flop synchronizer; reset high so a reset never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.i_rx};
        end
    end

    assign rx_s = sync_q[1];

    // A start edge is accepted only when no stale-line condition is pending.
    assign start_ok = (state == ST_IDLE) && !rx_s && !wait_high && !flushing && !bus.i_clear;

    // Restarting the divider on the start edge lines the sample points up with bit centres.
    baud_tick_gen #(
        .DIVISOR(DIVISOR)
    ) u_tick (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .clear  (start_ok),
        .tick   (tick)
    );

`ifdef UART_RX_PARITY_EN
    assign parity_ok = !parity_bad;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            s           <= '0;
            n           <= '0;
            shift_reg   <= '0;
            data_q      <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            wait_high   <= 1'b0;
            flushing    <= 1'b0;
            flush_cnt   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // After a frame error with the line stuck low, demand a fresh falling edge.
            if (rx_s) begin
                wait_high <= 1'b0;
            end

            // After a flush we are probably mid-character; only trust the line
            // again once it has stayed idle for a whole frame time.
            if (flushing) begin
                if (!rx_s) begin
                    flush_cnt <= '0;
                end else if (tick) begin
                    if (flush_cnt == F_LAST) begin
                        flushing <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
            end

            if (bus.i_clear) begin
                state     <= ST_IDLE;
                s         <= '0;
                n         <= '0;
                shift_reg <= '0;
                data_q    <= '0;
                busy_q    <= 1'b0;
                flushing  <= 1'b1;
                flush_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                parity_bad <= 1'b0;
`endif
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            state  <= ST_START;
                            s      <= '0;
                            busy_q <= 1'b1;
                        end
                    end

                    ST_START: begin
                        if (tick) begin
                            if (s == S_MID) begin
                                if (!rx_s) begin
                                    state <= ST_DATA;
                                    s     <= '0;
                                    n     <= '0;
                                end else begin
                                    // Line went back high before mid-start: a glitch.
                                    state  <= ST_IDLE;
                                    busy_q <= 1'b0;
                                end
                            end else begin
                                s <= s + 1'b1;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (tick) begin
                            if (s == S_LAST) begin
                                s         <= '0;
                                n         <= n + 1'b1;
                                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                                if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                    state <= ST_PARITY;
`else
                                    state <= ST_STOP;
`endif
                                end
                            end else begin
                                s <= s + 1'b1;
                            end
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (tick) begin
                            if (s == S_LAST) begin
                                s          <= '0;
                                // Even parity: data ones plus parity bit must be even.
                                parity_bad <= (^shift_reg) ^ rx_s;
                                state      <= ST_STOP;
                            end else begin
                                s <= s + 1'b1;
                            end
                        end
                    end
`endif

                    ST_STOP: begin
                        if (tick) begin
                            if (s == S_LAST) begin
                                s      <= '0;
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                if (!rx_s) begin
                                    frame_err_q <= 1'b1;
                                    wait_high   <= 1'b1;
                                end else if (parity_ok) begin
                                    data_q     <= shift_reg;
                                    rx_ready_q <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= parity_bad;
`endif
                            end else begin
                                s <= s + 1'b1;
                            end
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_rx_ready  = rx_ready_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with DIVISOR=4, SB_TICKS=16 (one bit = 64 i_clk).
// A table of frames with hand-derived results, directed corner-case sequences,
// then random frames checked against a rule-level model of the receiver.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int DIV = 4;
    localparam int SBT = 16;
    localparam int BIT = DIV * SBT;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Ready pulse expected at the middle of the stop bit, measured from the start edge.
    localparam int EXP_LAT = BIT * (9 + PBITS) + BIT / 2;
    localparam int LAT_TOL = 8;

    logic i_clk = 1'b0;
    logic i_reset;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rdy = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_both = 0;
    int last_rdy_cyc = 0;
    int start_cyc = 0;
    logic [7:0] rdy_q[$];
    logic [7:0] exp_data;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       flip;
        int         idle_bits;
        int         er;
        int         ef;
        int         ep;
        logic [7:0] edata;
    } vec_t;

    vec_t tbl[6];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS(8),
        .SB_TICKS (SBT),
        .DIVISOR  (DIV)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (bus.o_rx_ready) begin
            n_rdy        <= n_rdy + 1;
            last_rdy_cyc <= cyc;
            rdy_q.push_back(bus.o_data);
        end
        if (bus.o_frame_err) n_ferr <= n_ferr + 1;
        if (bus.o_rx_ready && bus.o_frame_err) n_both <= n_both + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.o_parity_err) n_perr <= n_perr + 1;
`endif
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.i_rx = v;
        repeat (BIT) @(negedge i_clk);
    endtask

    task automatic idle(input int nbits);
        bus.i_rx = 1'b1;
        repeat (nbits * BIT) @(negedge i_clk);
    endtask

    // Start, LSB-first data, optional even parity (flip corrupts it), stop.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ flip);
`endif
        drive_bit(stop);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                             input logic flip, input int idle_bits, input int er,
                             input int ef, input int ep, input logic [7:0] edata,
                             input bit chk_lat);
        int r0, f0, b0, lat;
`ifdef UART_RX_PARITY_EN
        int p0;
        p0 = n_perr;
`endif
        r0 = n_rdy;
        f0 = n_ferr;
        b0 = n_both;
        rdy_q.delete();
        send_frame(d, stop, flip);
        idle(idle_bits);
        check({tag, "_rdy_pulses"}, n_rdy - r0, er);
        check({tag, "_ferr_pulses"}, n_ferr - f0, ef);
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr_pulses"}, n_perr - p0, ep);
`endif
        check({tag, "_overlap"}, n_both - b0, 0);
        check({tag, "_o_data"}, int'(bus.o_data), int'(edata));
        if (er == 1 && rdy_q.size() > 0) begin
            check({tag, "_pulse_data"}, int'(rdy_q[0]), int'(d));
        end
        if (chk_lat && er == 1) begin
            lat = last_rdy_cyc - start_cyc;
            checks++;
            if (lat < EXP_LAT - LAT_TOL || lat > EXP_LAT + LAT_TOL) begin
                errors++;
                $display("FAIL %s_latency: got %0d cycles expected %0d +- %0d",
                         tag, lat, EXP_LAT, LAT_TOL);
            end
        end
    endtask

    // Watchdog: the run is purely time-driven, this only guards against a stuck sim.
    initial begin
        repeat (95000) @(posedge i_clk);
        errors++;
        $display("FAIL watchdog: cycle budget exhausted");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int r0, f0, b0;
        logic [7:0] rd;
        logic rstop, rflip;
        int rgap, er, ef, ep;

        tbl[0] = '{CMD_STEP, 1'b1, 1'b0, 1, 1, 0, 0, 8'h73};
        tbl[1] = '{CMD_INFO, 1'b0, 1'b0, 2, 0, 1, 0, 8'h73};
        tbl[2] = '{8'hA5,    1'b1, 1'b0, 1, 1, 0, 0, 8'hA5};
        tbl[3] = '{8'h00,    1'b1, 1'b0, 1, 1, 0, 0, 8'h00};
        tbl[4] = '{8'hFF,    1'b1, 1'b0, 0, 1, 0, 0, 8'hFF};
        tbl[5] = '{8'h80,    1'b0, 1'b0, 2, 0, 1, 0, 8'hFF};

        i_reset     = 1'b1;
        bus.i_rx    = 1'b1;
        bus.i_clear = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_o_data", int'(bus.o_data), 0);
        check("reset_rx_ready", int'(bus.o_rx_ready), 0);
        check("reset_frame_err", int'(bus.o_frame_err), 0);
        check("reset_busy", int'(bus.o_busy), 0);
        i_reset = 1'b0;
        idle(1);
        check("idle_busy", int'(bus.o_busy), 0);

        // Table of frames with fixed expectations.
        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop, tbl[i].flip,
                      tbl[i].idle_bits, tbl[i].er, tbl[i].ef, tbl[i].ep,
                      tbl[i].edata, 1'b1);
        end
        exp_data = 8'hFF;

        // 20-cycle low glitch on an idle line.
        r0 = n_rdy; f0 = n_ferr;
        bus.i_rx = 1'b0;
        repeat (10) @(negedge i_clk);
        check("glitch_busy_high", int'(bus.o_busy), 1);
        repeat (10) @(negedge i_clk);
        bus.i_rx = 1'b1;
        repeat (BIT) @(negedge i_clk);
        check("glitch_busy_low", int'(bus.o_busy), 0);
        check("glitch_rdy", n_rdy - r0, 0);
        check("glitch_ferr", n_ferr - f0, 0);

        // Frame error followed by a line held low: no restart until high then low.
        r0 = n_rdy; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            repeat (BIT) @(negedge i_clk);
            check($sformatf("held_low_busy%0d", b), int'(bus.o_busy), 0);
        end
        check("held_low_ferr", n_ferr - f0, 1);
        check("held_low_rdy", n_rdy - r0, 0);
        idle(2);
        exp_data = 8'h5A;
        run_frame("after_held_low", 8'h5A, 1'b1, 1'b0, 1, 1, 0, 0, exp_data, 1'b1);

        // Flush during data bit 3 of 0xA5.
        r0 = n_rdy; f0 = n_ferr;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (4 * BIT + BIT / 2) @(negedge i_clk);
                bus.i_clear = 1'b1;
                @(negedge i_clk);
                bus.i_clear = 1'b0;
                check("clear_busy", int'(bus.o_busy), 0);
                check("clear_o_data", int'(bus.o_data), 0);
            end
        join
        idle(12);
        check("clear_rdy", n_rdy - r0, 0);
        check("clear_ferr", n_ferr - f0, 0);
        exp_data = 8'h3C;
        run_frame("after_clear", 8'h3C, 1'b1, 1'b0, 1, 1, 0, 0, exp_data, 1'b1);

        // Reset in the stop bit, before its sample point.
        r0 = n_rdy;
        fork
            send_frame(8'h42, 1'b1, 1'b0);
            begin
                repeat ((9 + PBITS) * BIT + 14) @(negedge i_clk);
                i_reset = 1'b1;
                #1;
                check("midstop_rst_o_data", int'(bus.o_data), 0);
                check("midstop_rst_rdy", int'(bus.o_rx_ready), 0);
                check("midstop_rst_ferr", int'(bus.o_frame_err), 0);
                check("midstop_rst_busy", int'(bus.o_busy), 0);
                repeat (3) @(negedge i_clk);
                i_reset = 1'b0;
            end
        join
        idle(1);
        check("midstop_rst_no_pulse", n_rdy - r0, 0);
        r0 = n_rdy; f0 = n_ferr; b0 = n_both;
        rdy_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(1);
        check("b2b_rdy", n_rdy - r0, 2);
        check("b2b_ferr", n_ferr - f0, 0);
        check("b2b_overlap", n_both - b0, 0);
        if (rdy_q.size() == 2) begin
            check("b2b_first", int'(rdy_q[0]), 8'h00);
            check("b2b_second", int'(rdy_q[1]), 8'hFF);
        end
        exp_data = 8'hFF;
        check("b2b_o_data", int'(bus.o_data), int'(exp_data));

        // Random frames against the rule-level model.
        for (int k = 0; k < 20; k++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            rflip = ($urandom_range(0, 3) == 0);
`else
            rflip = 1'b0;
`endif
            rgap  = $urandom_range(1, 3);
            ef = rstop ? 0 : 1;
            ep = rflip ? 1 : 0;
            er = (rstop && !rflip) ? 1 : 0;
            if (er == 1) exp_data = rd;
            run_frame($sformatf("rnd%0d", k), rd, rstop, rflip, rgap, er, ef, ep,
                      exp_data, 1'b1);
        end

`ifdef UART_RX_PARITY_EN
        run_frame("par_bad", 8'h01, 1'b1, 1'b1, 1, 0, 0, 1, exp_data, 1'b0);
        exp_data = 8'h01;
        run_frame("par_good", 8'h01, 1'b1, 1'b0, 1, 1, 0, 0, exp_data, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
